// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages: main slot drives the outputs,
// skid slot absorbs one entry so in_ready never depends on out_ready.
module pipe_skid_reg #(
  parameter int unsigned        CTRL_W      = 16,
  parameter int unsigned        DATA_W      = 40,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
  parameter int unsigned        CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inject_bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic              accept_s;
  logic              consume_s;
  logic              bubble_ins_s;
  logic              enq_s;
  logic [CTRL_W-1:0] enq_ctrl_s;
  logic [DATA_W-1:0] enq_data_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Handshake decode; a bubble takes the place of the upstream entry.
  always_comb begin
    in_ready     = (state_q != FULL) && !flush && !inject_bubble;
    accept_s     = in_valid && in_ready;
    consume_s    = (state_q != EMPTY) && out_ready;
    bubble_ins_s = !flush && inject_bubble && (state_q != FULL);
    enq_s        = accept_s || bubble_ins_s;
    if (bubble_ins_s) begin
      enq_ctrl_s = BUBBLE_CTRL;
      enq_data_s = '0;
    end else begin
      enq_ctrl_s = in_ctrl;
      enq_data_s = in_data;
    end
  end

  // Next-state and slot contents; invalid slots are always kept at zero.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (enq_s) begin
            main_ctrl_d = enq_ctrl_s;
            main_data_d = enq_data_s;
            state_d     = ONE;
          end else begin
            state_d     = EMPTY;
          end
        end
        ONE: begin
          if (enq_s && consume_s) begin
            main_ctrl_d = enq_ctrl_s;
            main_data_d = enq_data_s;
          end else if (enq_s) begin
            skid_ctrl_d = enq_ctrl_s;
            skid_data_d = enq_data_s;
            state_d     = FULL;
          end else if (consume_s) begin
            main_ctrl_d = '0;
            main_data_d = '0;
            state_d     = EMPTY;
          end else begin
            state_d     = ONE;
          end
        end
        FULL: begin
          if (consume_s) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            skid_data_d = '0;
            state_d     = ONE;
          end else begin
            state_d     = FULL;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          main_data_d = '0;
          skid_ctrl_d = '0;
          skid_data_d = '0;
        end
      endcase
    end
  end

  // Bubble statistics survive flush and saturate at all-ones.
  always_comb begin
    if (bubble_ins_s) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= EMPTY;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = (state_q != EMPTY);
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign occupancy  = state_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table for the basic handshake cases, a FIFO
// scoreboard checked every cycle, and hand sequences for bubbles and streaming.
module tb_pipe_skid_reg;

  localparam logic [15:0] BUB = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst, flush, inject_bubble, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_ctrl, out_ctrl;
  logic [39:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [1:0]  bubble_cnt;

  always #5 clk = ~clk;

  pipe_skid_reg #(.CTRL_W(16), .DATA_W(40), .BUBBLE_CTRL(BUB), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .inject_bubble(inject_bubble),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic [15:0] ctrl;
    logic [39:0] data;
  } ent_t;

  typedef struct {
    logic        r, f, b, iv, ordy;
    logic [15:0] ctrl;
    logic [39:0] data;
    logic        ev;
    logic [39:0] ed;
    logic [1:0]  eo;
    logic        erdy;
  } vec_t;

  ent_t sb_q[$];
  vec_t vecs[11];
  int   checks = 0;
  int   failures = 0;
  logic [1:0] m_cnt = 2'd0;
  bit   known = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle, check outputs against the scoreboard, update model at the edge.
  task automatic step(input logic r, input logic f, input logic b, input logic iv,
                      input logic [15:0] c, input logic [39:0] d, input logic ordy);
    int   sz;
    ent_t e;
    rst = r; flush = f; inject_bubble = b; in_valid = iv;
    in_ctrl = c; in_data = d; out_ready = ordy;
    #1;
    sz = sb_q.size();
    if (known) begin
      chk("sb_occupancy", occupancy, sz);
      chk("sb_out_valid", out_valid, sz > 0);
      if (sz > 0) begin
        chk("sb_out_ctrl", out_ctrl, sb_q[0].ctrl);
        chk("sb_out_data", out_data, sb_q[0].data);
      end else begin
        chk("sb_idle_ctrl", out_ctrl, 0);
        chk("sb_idle_data", out_data, 0);
      end
      if (r) chk("sb_in_ready", in_ready, (sz < 2) && !f && !b);
    end
    if (!r) begin
      sb_q.delete();
      m_cnt = 2'd0;
      known = 1'b1;
    end else if (f) begin
      sb_q.delete();
    end else begin
      if (ordy && sz > 0) void'(sb_q.pop_front());
      if (b) begin
        if (sz < 2) begin
          e.ctrl = BUB; e.data = 40'h0;
          sb_q.push_back(e);
          if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        end
      end else if (iv && sz < 2) begin
        e.ctrl = c; e.data = d;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("sb_bubble_cnt", bubble_cnt, m_cnt);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; inject_bubble = 1'b0; in_valid = 1'b0;
    in_ctrl = 16'h0; in_data = 40'h0; out_ready = 1'b0;

    //            r     f     b     iv    ordy  ctrl      data             ev    ed               eo    erdy
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 40'h0,           1'b0, 40'h0,           2'd0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 40'h1122334455,  1'b1, 40'h1122334455,  2'd1, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 40'h0,           1'b0, 40'h0,           2'd0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00A1, 40'h01,          1'b1, 40'h01,          2'd1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00B2, 40'h02,          1'b1, 40'h01,          2'd2, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 40'h0,           1'b1, 40'h02,          2'd1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 40'h0,           1'b0, 40'h0,           2'd0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00A1, 40'h01,          1'b1, 40'h01,          2'd1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00B2, 40'h02,          1'b1, 40'h01,          2'd2, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00C3, 40'h03,          1'b0, 40'h0,           2'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 40'h0,           1'b0, 40'h0,           2'd0, 1'b1};

    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].r, vecs[i].f, vecs[i].b, vecs[i].iv, vecs[i].ctrl, vecs[i].data, vecs[i].ordy);
      chk($sformatf("tbl%0d_valid", i), out_valid, vecs[i].ev);
      chk($sformatf("tbl%0d_data", i), out_data, vecs[i].ed);
      chk($sformatf("tbl%0d_occ", i), occupancy, vecs[i].eo);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, vecs[i].erdy);
    end

    // Bubble behind a held entry, then drained in order.
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h00A1, 40'h01, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 40'h0, 1'b0);
    chk("bub_occ_full", occupancy, 2'd2);
    chk("bub_cnt_one", bubble_cnt, 2'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 40'h0, 1'b1);
    chk("bub_out_ctrl", out_ctrl, BUB);
    chk("bub_out_data", out_data, 40'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 40'h0, 1'b1);

    // Bubble request while FULL is dropped; consume still happens.
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h00A1, 40'h01, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h00B2, 40'h02, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 40'h0, 1'b0);
    chk("full_bub_occ", occupancy, 2'd2);
    chk("full_bub_cnt", bubble_cnt, 2'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 40'h0, 1'b1);
    chk("full_bub_consume_occ", occupancy, 2'd1);
    chk("full_bub_consume_data", out_data, 40'h02);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 40'h0, 1'b1);

    // Saturation of a 2-bit counter, untouched by flush.
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 40'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 40'h0, 1'b1);
    chk("sat_cnt", bubble_cnt, 2'd3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 40'h0, 1'b0);
    chk("flush_keeps_cnt", bubble_cnt, 2'd3);
    chk("flush_valid", out_valid, 1'b0);

    // Streaming at full rate, then reset mid-stream.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 16'(i + 16'h0040), 40'(i + 40'h100), 1'b1);
      chk($sformatf("stream%0d_occ", i), occupancy, 2'd1);
      chk($sformatf("stream%0d_data", i), out_data, 40'(i + 40'h100));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0077, 40'h777, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ctrl", out_ctrl, 16'h0);
    chk("rst_data", out_data, 40'h0);
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_cnt", bubble_cnt, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
